led_share_arbiter: RTL and testbench



---
 rtl/led_share_arbiter.sv | 132 +++++++++++++
 tb/tb_led_share_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the six active-low board LEDs among three sources.
// Built-in tick prescaler enforces a minimum visible hold per grant.
module led_share_arbiter #(
    parameter int TICK_COUNT = 13500000,
    parameter int HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic [5:0] pat0_i,
    input  logic [5:0] pat1_i,
    input  logic [5:0] pat2_i,
    output logic [2:0] grant_o,
    output logic       busy_o,
    output logic       tick_o,
    output logic [5:0] led_o
);

    localparam int CW = $clog2(TICK_COUNT);
    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_COUNT - 1);
    localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_pre;
    logic            r_tick;
    logic [2:0]      r_grant;
    logic            r_busy;
    logic [HW-1:0]   r_hold;
    logic [1:0]      r_last;
    logic [5:0]      r_led;

    logic [1:0]      w_c1;
    logic [1:0]      w_c2;
    logic [1:0]      w_win;
    logic            w_own_req;
    logic            w_other_req;
    logic            w_expired;
    logic            w_release;
    logic [5:0]      w_led_pat;

    function automatic logic [1:0] rr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Free-running prescaler; only reset touches it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == PRE_LAST);
            r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + CW'(1);
        end
    end

    assign w_c1 = rr_inc(r_last);
    assign w_c2 = rr_inc(w_c1);

    always_comb begin
        w_win = r_last;
        if (req_i[w_c1])
            w_win = w_c1;
        else if (req_i[w_c2])
            w_win = w_c2;
    end

    assign w_own_req   = |(req_i & r_grant);
    assign w_other_req = |(req_i & ~r_grant);
    assign w_expired   = (r_hold == HOLD_MAX);
    assign w_release   = !w_own_req || (w_expired && w_other_req);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_last  <= 2'd2;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|req_i) begin
                        r_state <= S_GRANT;
                        r_grant <= 3'b001 << w_win;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                        r_last  <= w_win;
                    end
                end
                S_GRANT: begin
                    if (r_tick && !w_expired)
                        r_hold <= r_hold + HW'(1);
                    // Always pass through IDLE so the LEDs blank between owners.
                    if (w_release) begin
                        r_state <= S_IDLE;
                        r_grant <= 3'b000;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_led_pat = 6'b000000;
        unique case (1'b1)
            r_grant[0]: w_led_pat = pat0_i;
            r_grant[1]: w_led_pat = pat1_i;
            r_grant[2]: w_led_pat = pat2_i;
            default:    w_led_pat = 6'b000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_led <= 6'b111111;
        else
            r_led <= ~w_led_pat;
    end

    assign grant_o = r_grant;
    assign busy_o  = r_busy;
    assign tick_o  = r_tick;
    assign led_o   = r_led;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter with TICK_COUNT=4, HOLD_TICKS=2.
// Each task drives one scenario and checks against hand-derived values.
module tb_led_share_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req_i;
    logic [5:0] pat0_i;
    logic [5:0] pat1_i;
    logic [5:0] pat2_i;
    logic [2:0] grant_o;
    logic       busy_o;
    logic       tick_o;
    logic [5:0] led_o;

    int errors = 0;
    int checks = 0;

    led_share_arbiter #(
        .TICK_COUNT(4),
        .HOLD_TICKS(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .pat0_i (pat0_i),
        .pat1_i (pat1_i),
        .pat2_i (pat2_i),
        .grant_o(grant_o),
        .busy_o (busy_o),
        .tick_o (tick_o),
        .led_o  (led_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the last reset edge, rst released.
    task automatic do_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        req_i = 3'b000;
        do_reset();
        checks++;
        if (grant_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_grant: got %b expected 000", grant_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        checks++;
        if (led_o !== 6'b111111) begin
            errors++;
            $display("FAIL reset_led: got %b expected 111111", led_o);
        end
        checks++;
        if (tick_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b expected 0", tick_o);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (tick_o !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL tick_k%0d: got %b expected %b",
                         k, tick_o, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_single();
        req_i = 3'b000;
        do_reset();
        pat1_i = 6'b000101;
        req_i  = 3'b010;
        step();
        checks++;
        if (grant_o !== 3'b010 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got %b/%b expected 010/1",
                     grant_o, busy_o);
        end
        checks++;
        if (led_o !== 6'b111111) begin
            errors++;
            $display("FAIL single_led0: got %b expected 111111", led_o);
        end
        step();
        checks++;
        if (led_o !== 6'b111010) begin
            errors++;
            $display("FAIL single_led1: got %b expected 111010", led_o);
        end
        req_i = 3'b000;
        step();
        checks++;
        if (grant_o !== 3'b000 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got %b/%b expected 000/0",
                     grant_o, busy_o);
        end
        checks++;
        if (led_o !== 6'b111010) begin
            errors++;
            $display("FAIL single_led2: got %b expected 111010", led_o);
        end
        step();
        checks++;
        if (led_o !== 6'b111111) begin
            errors++;
            $display("FAIL single_blank: got %b expected 111111", led_o);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_g;
        req_i = 3'b000;
        do_reset();
        req_i = 3'b111;
        for (int k = 1; k <= 27; k++) begin
            step();
            if (k <= 9)       exp_g = 3'b001;
            else if (k == 10) exp_g = 3'b000;
            else if (k <= 17) exp_g = 3'b010;
            else if (k == 18) exp_g = 3'b000;
            else if (k <= 25) exp_g = 3'b100;
            else if (k == 26) exp_g = 3'b000;
            else              exp_g = 3'b001;
            checks++;
            if (grant_o !== exp_g || busy_o !== (exp_g != 3'b000)) begin
                errors++;
                $display("FAIL fair_k%0d: got %b/%b expected %b/%b",
                         k, grant_o, busy_o, exp_g, exp_g != 3'b000);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0] exp_g;
        req_i = 3'b000;
        do_reset();
        req_i = 3'b001;
        step();
        checks++;
        if (grant_o !== 3'b001) begin
            errors++;
            $display("FAIL hold_first: got %b expected 001", grant_o);
        end
        req_i = 3'b101;
        for (int k = 2; k <= 11; k++) begin
            step();
            if (k <= 9)       exp_g = 3'b001;
            else if (k == 10) exp_g = 3'b000;
            else              exp_g = 3'b100;
            checks++;
            if (grant_o !== exp_g) begin
                errors++;
                $display("FAIL hold_k%0d: got %b expected %b",
                         k, grant_o, exp_g);
            end
        end
    endtask

    task automatic test_pattern();
        req_i  = 3'b000;
        do_reset();
        pat0_i = 6'b000000;
        pat1_i = 6'b000000;
        pat2_i = 6'b111111;
        req_i  = 3'b100;
        step();
        checks++;
        if (grant_o !== 3'b100) begin
            errors++;
            $display("FAIL pat_grant: got %b expected 100", grant_o);
        end
        step();
        checks++;
        if (led_o !== 6'b000000) begin
            errors++;
            $display("FAIL pat_all_on: got %b expected 000000", led_o);
        end
        pat2_i = 6'b000000;
        step();
        checks++;
        if (led_o !== 6'b111111) begin
            errors++;
            $display("FAIL pat_all_off: got %b expected 111111", led_o);
        end
        pat0_i = 6'b101010;
        pat1_i = 6'b010101;
        step();
        checks++;
        if (led_o !== 6'b111111) begin
            errors++;
            $display("FAIL pat_ignore: got %b expected 111111", led_o);
        end
        pat2_i = 6'b001100;
        step();
        checks++;
        if (led_o !== 6'b110011) begin
            errors++;
            $display("FAIL pat_track: got %b expected 110011", led_o);
        end
    endtask

    task automatic test_reset_mid_grant();
        req_i  = 3'b000;
        do_reset();
        pat1_i = 6'b000011;
        req_i  = 3'b010;
        repeat (3) step();
        checks++;
        if (grant_o !== 3'b010 || led_o !== 6'b111100) begin
            errors++;
            $display("FAIL mid_pre: got %b/%b expected 010/111100",
                     grant_o, led_o);
        end
        req_i = 3'b011;
        rst   = 1'b0;
        step();
        rst   = 1'b1;
        checks++;
        if (grant_o !== 3'b000 || busy_o !== 1'b0 ||
            tick_o !== 1'b0 || led_o !== 6'b111111) begin
            errors++;
            $display("FAIL mid_reset: got %b/%b/%b/%b expected 000/0/0/111111",
                     grant_o, busy_o, tick_o, led_o);
        end
        step();
        checks++;
        if (grant_o !== 3'b001) begin
            errors++;
            $display("FAIL mid_regrant: got %b expected 001", grant_o);
        end
    endtask

    initial begin
        rst    = 1'b0;
        req_i  = 3'b000;
        pat0_i = 6'b000000;
        pat1_i = 6'b000000;
        pat2_i = 6'b000000;
        test_reset();
        test_single();
        test_fairness();
        test_hold();
        test_pattern();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
